// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the NOP word and the default reset PC.
package pc_fetch_stage_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN
   } fetch_state_e;

   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load enable and bubble/flush clear.
// Clear wins over enable and leaves a NOP behind an invalid slot.
module if_id_reg
   import pc_fetch_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [31:0]  instr_i,
   input  logic [W-1:0] pc_i,
   input  logic [W-1:0] pcplus4_i,
   output logic [31:0]  instr_o,
   output logic [W-1:0] pc_o,
   output logic [W-1:0] pcplus4_o,
   output logic         valid_o
);

   logic [31:0]  instr_q;
   logic [W-1:0] pc_q;
   logic [W-1:0] pcplus4_q;
   logic         valid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instr_q   <= NOP;
         pc_q      <= '0;
         pcplus4_q <= '0;
         valid_q   <= 1'b0;
      end else if (clr_i) begin
         instr_q   <= NOP;
         valid_q   <= 1'b0;
      end else if (en_i) begin
         instr_q   <= instr_i;
         pc_q      <= pc_i;
         pcplus4_q <= pcplus4_i;
         valid_q   <= 1'b1;
      end
   end

   assign instr_o   = instr_q;
   assign pc_o      = pc_q;
   assign pcplus4_o = pcplus4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem handshake, IF/ID reg.
// Optional perf counters are enabled with the FETCH_PERF_EN macro.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int           W        = 32,
   parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEF)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] pcnextF,
   input  logic         stallD,
   input  logic         flushD,
   output logic         imem_req,
   output logic [W-1:0] imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic [W-1:0] pcF,
   output logic [W-1:0] pcplus4F,
   output logic [31:0]  instrD,
   output logic [W-1:0] pcD,
   output logic [W-1:0] pcplus4D,
   output logic         validD,
   output logic         fetch_busyF
`ifdef FETCH_PERF_EN
  ,output logic [31:0]  perf_fetch_cnt,
   output logic [31:0]  perf_stall_cnt
`endif
);

   fetch_state_e state_q, state_d;
   logic [W-1:0] pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         deliver;
   logic         clr;
   logic [31:0]  instr_sel;

   assign pcF       = pc_q;
   assign pcplus4F  = pc_q + W'(4);
   assign imem_addr = pc_q;
   assign imem_req  = (state_q == S_REQ);

   // A held word is preferred over the bus once the stall lifts.
   assign instr_sel = (state_q == S_HOLD) ? hold_q : imem_rdata;

   always_comb begin
      deliver = 1'b0;
      if (!flushD && !stallD) begin
         deliver = ((state_q == S_WAIT) && imem_rvalid) ||
                   (state_q == S_HOLD);
      end
   end

   assign fetch_busyF = !deliver;
   assign clr         = flushD || (!stallD && !deliver);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      unique case (state_q)
         S_REQ: begin
            if (flushD) pc_d = pcnextF;
            else if (imem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flushD) begin
               pc_d    = pcnextF;
               state_d = imem_rvalid ? S_REQ : S_DRAIN;
            end else if (imem_rvalid) begin
               if (stallD) begin
                  hold_d  = imem_rdata;
                  state_d = S_HOLD;
               end else begin
                  pc_d    = pcnextF;
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (flushD) begin
               pc_d    = pcnextF;
               hold_d  = NOP;
               state_d = S_REQ;
            end else if (!stallD) begin
               pc_d    = pcnextF;
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            // The orphaned response must still be swallowed after a redirect.
            if (flushD) pc_d = pcnextF;
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= NOP;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   if_id_reg #(.W(W)) u_if_id (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (deliver),
      .clr_i     (clr),
      .instr_i   (instr_sel),
      .pc_i      (pc_q),
      .pcplus4_i (pcplus4F),
      .instr_o   (instrD),
      .pc_o      (pcD),
      .pcplus4_o (pcplus4D),
      .valid_o   (validD)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (deliver)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (fetch_busyF) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage.
// Define FETCH_PERF_EN to also exercise the performance counters.
module tb_pc_fetch_stage;
   import pc_fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pcnextF;
   logic        stallD, flushD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pcF, pcplus4F;
   logic [31:0] instrD, pcD, pcplus4D;
   logic        validD, fetch_busyF;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

   logic        use_tgt;
   logic [31:0] tgt;
   int          checks = 0;
   int          failures = 0;

   // Bench-side PC mux: sequential unless a redirect target is forced.
   assign pcnextF = use_tgt ? tgt : pcplus4F;

   always #5 clk = ~clk;

   pc_fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pcnextF     (pcnextF),
      .stallD      (stallD),
      .flushD      (flushD),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pcF         (pcF),
      .pcplus4F    (pcplus4F),
      .instrD      (instrD),
      .pcD         (pcD),
      .pcplus4D    (pcplus4D),
      .validD      (validD),
      .fetch_busyF (fetch_busyF)
`ifdef FETCH_PERF_EN
     ,.perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stallD = 1'b0; flushD = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      use_tgt = 1'b0; tgt = 32'h0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic fetch_one(input logic [31:0] d);
      imem_gnt = 1'b1; imem_rvalid = 1'b0;
      step();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d;
      step();
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pcF !== 32'h0) begin failures++; $display("FAIL rst_pcF got=%h exp=%h", pcF, 32'h0); end
      checks++; if (validD !== 1'b0) begin failures++; $display("FAIL rst_validD got=%b exp=0", validD); end
      checks++; if (instrD !== 32'h0000_0013) begin failures++; $display("FAIL rst_instrD got=%h exp=00000013", instrD); end
      checks++; if (pcD !== 32'h0 || pcplus4D !== 32'h0) begin failures++; $display("FAIL rst_pcD got=%h/%h exp=0/0", pcD, pcplus4D); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_req got=%b/%h exp=1/0", imem_req, imem_addr); end
      checks++; if (pcplus4F !== 32'h4) begin failures++; $display("FAIL rst_pcplus4F got=%h exp=4", pcplus4F); end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         imem_gnt = 1'b1; imem_rvalid = 1'b0;
         step();
         checks++; if (validD !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got=%b/%b exp=0/0", k, validD, imem_req); end
         imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_0000 + 32'(k);
         step();
         checks++; if (validD !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", k, validD); end
         checks++; if (pcD !== 32'(4*k)) begin failures++; $display("FAIL seq_pcD%0d got=%h exp=%h", k, pcD, 32'(4*k)); end
         checks++; if (instrD !== 32'hC0DE_0000 + 32'(k)) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", k, instrD, 32'hC0DE_0000 + 32'(k)); end
         checks++; if (pcplus4D !== 32'(4*k+4) || pcF !== 32'(4*k+4)) begin failures++; $display("FAIL seq_pc%0d got=%h/%h exp=%h", k, pcplus4D, pcF, 32'(4*k+4)); end
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      fetch_one(32'hAAAA_0000);
      stallD = 1'b1; imem_gnt = 1'b1;
      step();
      checks++; if (validD !== 1'b1 || pcD !== 32'h0) begin failures++; $display("FAIL stall_c1 got=%b/%h exp=1/0", validD, pcD); end
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0004;
      step();
      imem_rvalid = 1'b0;
      checks++; if (validD !== 1'b1 || instrD !== 32'hAAAA_0000) begin failures++; $display("FAIL stall_c2 got=%b/%h exp=1/aaaa0000", validD, instrD); end
      checks++; if (fetch_busyF !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b/%b exp=1/0", fetch_busyF, imem_req); end
      step();
      checks++; if (pcD !== 32'h0 || validD !== 1'b1) begin failures++; $display("FAIL stall_c3 got=%h/%b exp=0/1", pcD, validD); end
      stallD = 1'b0;
      #1;
      checks++; if (fetch_busyF !== 1'b0) begin failures++; $display("FAIL stall_busy got=%b exp=0", fetch_busyF); end
      step();
      checks++; if (validD !== 1'b1 || pcD !== 32'h4) begin failures++; $display("FAIL stall_rel got=%b/%h exp=1/4", validD, pcD); end
      checks++; if (instrD !== 32'hBBBB_0004 || pcF !== 32'h8) begin failures++; $display("FAIL stall_rel_instr got=%h/%h exp=bbbb0004/8", instrD, pcF); end
   endtask

   task automatic test_flush_wait();
      do_reset();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; flushD = 1'b1; use_tgt = 1'b1; tgt = 32'h100;
      step();
      flushD = 1'b0; use_tgt = 1'b0;
      checks++; if (pcF !== 32'h100 || validD !== 1'b0) begin failures++; $display("FAIL fw_redir got=%h/%b exp=100/0", pcF, validD); end
      step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fw_drain_req got=%b exp=0", imem_req); end
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      checks++; if (validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL fw_discard got=%b/%b/%h exp=0/1/100", validD, imem_req, imem_addr); end
      fetch_one(32'h1234_5678);
      checks++; if (validD !== 1'b1 || pcD !== 32'h100 || instrD !== 32'h1234_5678) begin failures++; $display("FAIL fw_next got=%b/%h/%h exp=1/100/12345678", validD, pcD, instrD); end
   endtask

   task automatic test_flush_rvalid();
      do_reset();
      fetch_one(32'h0000_0001);
      stallD = 1'b1; imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; flushD = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      use_tgt = 1'b1; tgt = 32'h200;
      step();
      flushD = 1'b0; imem_rvalid = 1'b0; use_tgt = 1'b0; stallD = 1'b0;
      checks++; if (validD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL fr_drop got=%b/%b/%h exp=0/1/200", validD, imem_req, imem_addr); end
      fetch_one(32'h0000_0005);
      checks++; if (pcD !== 32'h200 || instrD !== 32'h5 || validD !== 1'b1) begin failures++; $display("FAIL fr_next got=%h/%h/%b exp=200/5/1", pcD, instrD, validD); end
   endtask

   task automatic test_wrap();
      do_reset();
      flushD = 1'b1; use_tgt = 1'b1; tgt = 32'hFFFF_FFFC;
      step();
      flushD = 1'b0; use_tgt = 1'b0;
      checks++; if (pcF !== 32'hFFFF_FFFC || pcplus4F !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", pcF, pcplus4F); end
      fetch_one(32'h0000_0007);
      checks++; if (pcD !== 32'hFFFF_FFFC || pcplus4D !== 32'h0 || pcF !== 32'h0) begin failures++; $display("FAIL wrap_d got=%h/%h/%h exp=fffffffc/0/0", pcD, pcplus4D, pcF); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_one(32'h0000_0001);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      checks++; if (pcF !== 32'h4) begin failures++; $display("FAIL rm_pre got=%h exp=4", pcF); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (pcF !== 32'h0 || validD !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL rm_async got=%h/%b/%b exp=0/0/1", pcF, validD, imem_req); end
      step();
      rst_n = 1'b1;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
      step();
      imem_rvalid = 1'b0;
      checks++; if (validD !== 1'b0 || imem_req !== 1'b1 || pcF !== 32'h0) begin failures++; $display("FAIL rm_stale got=%b/%b/%h exp=0/1/0", validD, imem_req, pcF); end
      fetch_one(32'h0000_0009);
      checks++; if (pcD !== 32'h0 || instrD !== 32'h9 || validD !== 1'b1) begin failures++; $display("FAIL rm_next got=%h/%h/%b exp=0/9/1", pcD, instrD, validD); end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin failures++; $display("FAIL perf_rst got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
      for (int k = 0; k < 4; k++) fetch_one(32'(k));
      imem_gnt = 1'b0;
      step(); step(); step();
      checks++; if (perf_fetch_cnt !== 32'd4 || perf_stall_cnt !== 32'd7) begin failures++; $display("FAIL perf_cnt got=%0d/%0d exp=4/7", perf_fetch_cnt, perf_stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_flush_wait();
      test_flush_rvalid();
      test_wrap();
      test_reset_mid();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
